mips_bus_master: RTL
====================

MIPS_BUS_MASTER -- requirements
Module: mips_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of consecutive waitrequest-high cycles before a bus access is aborted.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-004 req_valid  in  1  load/store request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout.
REQ-014 address  out  32  word-aligned bus address (req_addr with bits [1:0] forced to 00).
REQ-015 read, write  out  1 each  bus strobes; never both high.
REQ-016 byteenable  out  4  active byte lanes.
REQ-017 writedata  out  32  lane-positioned store data.
REQ-018 readdata  in  32  bus read data, valid on the completing edge.
REQ-019 waitrequest  in  1  responder stall.

Function
REQ-020 Lane mapping SHALL be little-endian: byte at req_addr[1:0]=k occupies readdata/writedata bits [8k+7:8k].
REQ-021 byteenable SHALL be 0001<<k for byte, 0011 (k=0) or 1100 (k=2) for half, and 1111 for word.
REQ-022 writedata SHALL carry req_wdata shifted left by 8k bits; bits of unenabled lanes SHALL be 0.
REQ-023 The FSM SHALL have exactly three states: IDLE, BUS, RESP.
REQ-024 req_ready SHALL be high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high, and all request fields are registered on that edge.
REQ-025 An accepted legal, aligned request SHALL move the FSM to BUS; read or write rises in the cycle after acceptance.
REQ-026 In BUS, the strobe, address, byteenable and writedata SHALL remain stable until an edge where waitrequest is low; that edge completes the access, readdata is sampled on it, and the FSM moves to RESP.
REQ-027 With waitrequest held low, the strobe SHALL be high for exactly one cycle, giving 3 cycles from acceptance to resp_valid.
REQ-028 In RESP, resp_valid SHALL be high for exactly one cycle and the FSM SHALL then return to IDLE.
REQ-029 Load data SHALL be extracted from lane k and extended to 32 bits per req_signed; word loads are passed through unchanged.
REQ-030 Misalignment is half with k odd, or word with k != 0. A misaligned request or size 11 SHALL cause no bus strobe, SHALL go directly to RESP, and SHALL respond with resp_err=1 and resp_rdata=0.
REQ-031 A wait counter SHALL count consecutive waitrequest-high cycles in BUS and SHALL clear on entry to BUS.
REQ-032 When the wait counter reaches TIMEOUT, the strobe SHALL drop on the next edge, the FSM SHALL enter RESP, and resp_err=1 SHALL be reported.
REQ-033 Outputs other than resp_rdata and resp_err SHALL be unaffected by request inputs while not in IDLE.

Reset
REQ-034 While reset is low: state IDLE, req_ready=1, read=0, write=0, byteenable=0000, address=0, writedata=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
REQ-035 Reset asserted during BUS SHALL drop the strobes asynchronously, and no response SHALL be produced for the aborted access.
REQ-036 The first request SHALL be accepted on the first rising edge after reset returns high.

Verification
REQ-037 Load word: req_addr=0x00000100, size 10, readdata=0xDEADBEEF, waitrequest=0 -> read for 1 cycle, address=0x100, byteenable=1111, resp_rdata=0xDEADBEEF, resp_valid 3 cycles after acceptance.
REQ-038 Signed and unsigned byte load: req_addr=0x103, readdata=0x80FF0000 -> byteenable=1000; signed gives 0xFFFFFF80, unsigned gives 0x00000080.
REQ-039 Half store: req_addr=0x202, req_wdata=0x1234ABCD -> write, address=0x200, byteenable=1100, writedata=0xABCD0000, resp_rdata=0.
REQ-040 Stall: waitrequest high for 5 cycles during a word store -> strobe and outputs stable for 6 cycles, one resp_valid, resp_err=0.
REQ-041 Errors: lw at 0x102 -> no strobe, resp_err=1 two cycles after acceptance; TIMEOUT=4 with waitrequest stuck high -> strobe drops, resp_err=1.
REQ-042 Reset pulse mid-BUS -> read/write low immediately, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/mips_bus_master_if.sv
// Request/response and bus signals of the MIPS load/store bus master.
// The master modport is the bus master itself; slave is the requester/responder side.
interface mips_bus_master_if;
  // Load/store request side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Completion side
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // Memory-mapped bus side
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  readdata, waitrequest,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output address, read, write, byteenable, writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output readdata, waitrequest,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  address, read, write, byteenable, writedata
  );
endinterface

// File: rtl/mips_bus_master.sv
// MIPS load/store bus master: turns byte/half/word requests into single
// word-aligned bus accesses with little-endian lane steering, load extension,
// alignment checking and a waitrequest timeout.
module mips_bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mips_bus_master_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic [31:0]     address_q, address_d;
  logic [3:0]      byteenable_q, byteenable_d;
  logic [31:0]     writedata_q, writedata_d;
  logic [1:0]      size_q, size_d;
  logic [1:0]      lane_q, lane_d;
  logic            sext_q, sext_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [1:0]  req_lane;
  logic        req_bad;
  logic [3:0]  req_be;
  logic [31:0] req_lane_mask;
  logic [31:0] req_wdata_pos;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  // Decode the incoming request: lane enables, alignment/size legality, positioned store data.
  always_comb begin
    req_lane = bus.req_addr[1:0];
    case (bus.req_size)
      2'b00: begin
        req_be  = 4'b0001 << req_lane;
        req_bad = 1'b0;
      end
      2'b01: begin
        req_be  = req_lane[1] ? 4'b1100 : 4'b0011;
        req_bad = req_lane[0];
      end
      2'b10: begin
        req_be  = 4'b1111;
        req_bad = (req_lane != 2'b00);
      end
      default: begin
        req_be  = 4'b0000;
        req_bad = 1'b1;
      end
    endcase
    req_lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
    req_wdata_pos = (bus.req_wdata << {req_lane, 3'b000}) & req_lane_mask;
  end

  // Pull the addressed lane(s) down to bit 0 and extend to 32 bits.
  always_comb begin
    rd_shift = bus.readdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/BUS/RESP sequence.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    size_d       = size_q;
    lane_d       = lane_q;
    sext_d       = sext_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (req_bad) begin
            // Misaligned or illegal size: skip the bus entirely.
            state_d      = StResp;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d      = StBus;
            wait_cnt_d   = '0;
            read_d       = ~bus.req_write;
            write_d      = bus.req_write;
            address_d    = {bus.req_addr[31:2], 2'b00};
            byteenable_d = req_be;
            writedata_d  = req_wdata_pos;
            size_d       = bus.req_size;
            lane_d       = req_lane;
            sext_d       = bus.req_signed;
          end
        end
      end

      StBus: begin
        // A low waitrequest completes the access even on the timeout cycle.
        if (!bus.waitrequest || (wait_cnt_q == CntW'(TIMEOUT))) begin
          state_d      = StResp;
          read_d       = 1'b0;
          write_d      = 1'b0;
          address_d    = 32'h0;
          byteenable_d = 4'b0000;
          writedata_d  = 32'h0;
          if (!bus.waitrequest) begin
            resp_err_d   = 1'b0;
            resp_rdata_d = read_q ? load_data : 32'h0;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      StResp: begin
        state_d      = StIdle;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any access with no response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0;
      byteenable_q <= 4'b0000;
      writedata_q  <= 32'h0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      sext_q       <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      sext_q       <= sext_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.byteenable = byteenable_q;
  assign bus.writedata  = writedata_q;

endmodule
